axi_lite_master_arb: RTL and testbench
======================================

// Module: axi_lite_master_arb
// PURPOSE
//  Parametrised AXI4-Lite master port shared by NREQ core-side requesters (fetch, load/store, DMA, ...).
//  Arbitrates requesters, runs one AXI transaction at a time, and returns rdata/error to the winner.
//  Sits between the core memory clients and the external AXI4-Lite bus.
//  Replaces the single-client memory port with N clients, byte strobes, response errors and fair arbitration.
// PARAMETERS
//  NREQ  2   number of requesters (1..8)
//  AW    32  address width
//  DW    32  data width (32 or 64); strobe width SW = DW/8
//  PROT  3'b000  value driven on ARprot/AWprot
// PORTS
//  clk        in   1          clock; all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  req_valid  in   NREQ       requester i has a request pending
//  req_we     in   NREQ       1 = write, 0 = read
//  req_addr   in   NREQ*AW    packed addresses, slice i = [i*AW +: AW]
//  req_wdata  in   NREQ*DW    packed write data
//  req_wstrb  in   NREQ*SW    packed byte strobes
//  req_ready  out  NREQ       one-hot; request i accepted this cycle
//  rsp_valid  out  NREQ       one-hot 1-cycle pulse; response for requester i
//  rsp_rdata  out  DW         read data (valid with rsp_valid, reads only)
//  rsp_err    out  1          RRESP/BRESP[1] was set (SLVERR/DECERR)
//  ARvalid/ARready/ARdata[AW]/ARprot[3]            AXI read address channel
//  Rvalid/RReady/Rdata[DW]/Rresp[2]                AXI read data channel
//  AWvalid/AWready/AWdata[AW]/AWprot[3]            AXI write address channel
//  Wvalid/Wready/Wdata[DW]/Wstrb[SW]               AXI write data channel
//  Bvalid/Bready/Bresp[2]                          AXI write response channel
// BEHAVIOUR
//  Reset: state=IDLE; all *valid, *ready, req_ready, rsp_valid, rsp_err = 0; rsp_rdata = 0;
//   round-robin pointer = 0; AR/AW/W data regs = 0.
//  States: IDLE -> RD_A -> RD_D -> RESP -> IDLE; IDLE -> WR_AW -> WR_B -> RESP -> IDLE.
//  IDLE: if any req_valid, pick winner g; pulse req_ready[g] for 1 cycle; latch addr/wdata/wstrb/we.
//   Next cycle enters RD_A (we=0) or WR_AW (we=1) with ARvalid or AWvalid+Wvalid high.
//  RD_A: hold ARvalid and ARdata stable until ARready; then RD_D with RReady=1.
//  RD_D: on Rvalid, capture Rdata and Rresp; RReady drops; go to RESP.
//  WR_AW: AWvalid and Wvalid raised together; each drops independently on its own ready.
//   Accept AWready/Wready in the same or in different cycles, in either order.
//   When both are done, go to WR_B with Bready=1.
//  WR_B: on Bvalid, capture Bresp; Bready drops; go to RESP.
//  RESP: rsp_valid[g]=1 for exactly one cycle; rsp_err=resp[1]; rsp_rdata=captured data (0 for writes).
//   rsp_err/rsp_rdata hold until the next RESP. Back to IDLE.
//  Latency: a zero-wait read gives req_ready at T, ARvalid at T+1, Rvalid at T+2, rsp_valid at T+3.
//   Min turnaround between grants is 4 cycles.
//  Valid stability: a raised AXI valid is never dropped before its ready (AXI rule).
//  Arbitration (default round-robin): search starts at ptr; after a grant to g, ptr = (g+1) mod NREQ.
//   Wrap-around: g = NREQ-1 sets ptr = 0.
//  Requesters hold req_* until req_ready. A req_valid drop before grant is ignored, with no side effects.
//  Only one transaction is outstanding. Requests arriving mid-transaction wait; there is no starvation.
//  rst asserted mid-transaction: return to IDLE next cycle; all valids/readies drop; no rsp_valid is issued.
// CONFIGURATION
//  FIXED_PRIO_EN defined: fixed priority, lowest index wins; ptr is unused and removed.
//  FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING
//  T1: NREQ=2; req0 read 0x100, slave returns 0xDEADBEEF with 0 waits
//   -> ARdata=0x100; rsp_valid=2'b01 at T+3; rsp_rdata=0xDEADBEEF; rsp_err=0.
//  T2: req1 write 0x200 data 0x12345678 strb 4'b0011; AWready 2 cycles after Wready
//   -> Wvalid drops first, AWvalid holds until ready; Bready only after both; rsp_valid=2'b10.
//  T3: req0 and req1 both valid continuously with reads
//   -> grants alternate 0,1,0,1; ptr wraps 1->0; with FIXED_PRIO_EN, only req0 is granted.
//  T4: read with Rresp=2'b10 -> rsp_err=1; next write with Bresp=2'b00 -> rsp_err=0.
//  T5: ARready held low 5 cycles
//   -> ARvalid and ARdata stable all 5 cycles; no second grant during the transaction.
//  T6: rst during RD_D -> next cycle all AXI valids/readies=0, state IDLE, no rsp_valid;
//   a fresh read completes normally afterwards.

Source files
------------

// File: rtl/axi_lite_master_arb.sv
// axi_lite_master_arb: AXI4-Lite master port shared by NREQ core-side requesters.
// One transaction is in flight at a time. The winner's address, data and strobes are
// latched at grant, and the read data / error is returned to that requester.
// Build option: define FIXED_PRIO_EN to make the lowest index always win. In that build
// the round-robin pointer does not exist. The default build uses round-robin.
//
// Handshake rule on every channel, request side and AXI side alike: a transfer happens on
// the rising edge where valid and ready are both high. A raised valid holds its payload
// stable until that edge. req_ready and rsp_valid are single-cycle pulses.
module axi_lite_master_arb #(
   parameter int         NREQ = 2,
   parameter int         AW   = 32,
   parameter int         DW   = 32,
   parameter logic [2:0] PROT = 3'b000
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NREQ-1:0]        i_req_valid,
   input  logic [NREQ-1:0]        i_req_we,
   input  logic [NREQ*AW-1:0]     i_req_addr,
   input  logic [NREQ*DW-1:0]     i_req_wdata,
   input  logic [NREQ*DW/8-1:0]   i_req_wstrb,
   output logic [NREQ-1:0]        o_req_ready,
   output logic [NREQ-1:0]        o_rsp_valid,
   output logic [DW-1:0]          o_rsp_rdata,
   output logic                   o_rsp_err,
   output logic                   o_ARvalid,
   input  logic                   i_ARready,
   output logic [AW-1:0]          o_ARdata,
   output logic [2:0]             o_ARprot,
   input  logic                   i_Rvalid,
   output logic                   o_RReady,
   input  logic [DW-1:0]          i_Rdata,
   input  logic [1:0]             i_Rresp,
   output logic                   o_AWvalid,
   input  logic                   i_AWready,
   output logic [AW-1:0]          o_AWdata,
   output logic [2:0]             o_AWprot,
   output logic                   o_Wvalid,
   input  logic                   i_Wready,
   output logic [DW-1:0]          o_Wdata,
   output logic [DW/8-1:0]        o_Wstrb,
   input  logic                   i_Bvalid,
   output logic                   o_Bready,
   input  logic [1:0]             i_Bresp,
   output logic [2:0]             o_dbg_state
);

   localparam int SW = DW / 8;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD_A  = 3'd1;
   localparam logic [2:0] S_RD_D  = 3'd2;
   localparam logic [2:0] S_WR_AW = 3'd3;
   localparam logic [2:0] S_WR_B  = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   logic [2:0]    r_state;
   logic [2:0]    r_gnt;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [SW-1:0] r_wstrb;
   logic          r_arvalid;
   logic          r_rready;
   logic          r_awvalid;
   logic          r_wvalid;
   logic          r_bready;
   logic [DW-1:0] r_rsp_rdata;
   logic          r_rsp_err;
`ifndef FIXED_PRIO_EN
   logic [2:0]    r_ptr;
`endif

   logic          w_any;
   logic [2:0]    w_gnt;
   logic          w_unused;

   // Only the upper response bit (SLVERR/DECERR) is reported back.
   assign w_unused = &{1'b0, i_Rresp[0], i_Bresp[0]};

   // Winner selection. The descending loop lets the lowest search offset win.
   always_comb begin
      w_any = 1'b0;
      w_gnt = 3'd0;
`ifdef FIXED_PRIO_EN
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (i_req_valid[k]) begin
            w_any = 1'b1;
            w_gnt = 3'(k);
         end
      end
`else
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (i_req_valid[(int'(r_ptr) + k) % NREQ]) begin
            w_any = 1'b1;
            w_gnt = 3'((int'(r_ptr) + k) % NREQ);
         end
      end
`endif
   end

   // Transaction sequencer: grant, AXI address/data phases, response capture, response pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_gnt       <= 3'd0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
`ifndef FIXED_PRIO_EN
         r_ptr       <= 3'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt   <= w_gnt;
                  r_addr  <= i_req_addr[int'(w_gnt) * AW +: AW];
                  r_wdata <= i_req_wdata[int'(w_gnt) * DW +: DW];
                  r_wstrb <= i_req_wstrb[int'(w_gnt) * SW +: SW];
`ifndef FIXED_PRIO_EN
                  r_ptr   <= (w_gnt == 3'(NREQ - 1)) ? 3'd0 : w_gnt + 3'd1;
`endif
                  if (i_req_we[w_gnt]) begin
                     r_state   <= S_WR_AW;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                  end else begin
                     r_state   <= S_RD_A;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            S_RD_A: begin
               if (i_ARready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RD_D;
               end
            end
            S_RD_D: begin
               if (i_Rvalid) begin
                  r_rready    <= 1'b0;
                  r_rsp_rdata <= i_Rdata;
                  r_rsp_err   <= i_Rresp[1];
                  r_state     <= S_RESP;
               end
            end
            S_WR_AW: begin
               // AW and W complete independently; move on once neither is still pending.
               if (i_AWready) r_awvalid <= 1'b0;
               if (i_Wready)  r_wvalid  <= 1'b0;
               if ((!r_awvalid || i_AWready) && (!r_wvalid || i_Wready)) begin
                  r_bready <= 1'b1;
                  r_state  <= S_WR_B;
               end
            end
            S_WR_B: begin
               if (i_Bvalid) begin
                  r_bready    <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= i_Bresp[1];
                  r_state     <= S_RESP;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_ready = (r_state == S_IDLE && w_any && !i_rst) ? (NREQ'(1) << w_gnt) : '0;
   assign o_rsp_valid = (r_state == S_RESP && !i_rst) ? (NREQ'(1) << r_gnt) : '0;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;
   assign o_ARvalid   = r_arvalid;
   assign o_ARdata    = r_addr;
   assign o_ARprot    = PROT;
   assign o_RReady    = r_rready;
   assign o_AWvalid   = r_awvalid;
   assign o_AWdata    = r_addr;
   assign o_AWprot    = PROT;
   assign o_Wvalid    = r_wvalid;
   assign o_Wdata     = r_wdata;
   assign o_Wstrb     = r_wstrb;
   assign o_Bready    = r_bready;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_lite_master_arb.sv
// Testbench for axi_lite_master_arb (NREQ=2, AW=DW=32): a vector table of single
// transactions plus hand-timed sequences for write ordering, arbitration, AR back-pressure
// and reset during a read.
module tb_axi_lite_master_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_we;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_wstrb;
   logic [1:0]  req_ready, rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        ar_valid, ar_ready;
   logic [31:0] ar_data;
   logic [2:0]  ar_prot;
   logic        r_valid, r_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        aw_valid, aw_ready;
   logic [31:0] aw_data;
   logic [2:0]  aw_prot;
   logic        w_valid, w_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        b_valid, b_ready;
   logic [1:0]  b_resp;
   logic [2:0]  dbg_state;

   // slave model knobs and counters
   int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   logic [31:0] s_rdata = '0;
   logic [1:0]  s_rresp = '0, s_bresp = '0;

   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      int          req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] s_rdata;
      logic [1:0]  s_resp;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[7];

   axi_lite_master_arb #(.NREQ(2), .AW(32), .DW(32), .PROT(3'b000)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
      .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
      .o_req_ready(req_ready), .o_rsp_valid(rsp_valid),
      .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
      .o_ARvalid(ar_valid), .i_ARready(ar_ready), .o_ARdata(ar_data), .o_ARprot(ar_prot),
      .i_Rvalid(r_valid), .o_RReady(r_ready), .i_Rdata(r_data), .i_Rresp(r_resp),
      .o_AWvalid(aw_valid), .i_AWready(aw_ready), .o_AWdata(aw_data), .o_AWprot(aw_prot),
      .o_Wvalid(w_valid), .i_Wready(w_ready), .o_Wdata(w_data), .o_Wstrb(w_strb),
      .i_Bvalid(b_valid), .o_Bready(b_ready), .i_Bresp(b_resp),
      .o_dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // AXI slave model: readies/valids updated on the falling edge, each after a configurable wait.
   initial begin
      ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0;
      aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
      forever begin
         @(negedge clk);
         if (ar_valid) begin
            if (ar_cnt >= ar_wait) ar_ready = 1'b1;
            else begin ar_ready = 1'b0; ar_cnt++; end
         end else begin ar_ready = 1'b0; ar_cnt = 0; end
         if (r_ready) begin
            if (r_cnt >= r_wait) begin r_valid = 1'b1; r_data = s_rdata; r_resp = s_rresp; end
            else begin r_valid = 1'b0; r_cnt++; end
         end else begin r_valid = 1'b0; r_cnt = 0; r_data = '0; r_resp = '0; end
         if (aw_valid) begin
            if (aw_cnt >= aw_wait) aw_ready = 1'b1;
            else begin aw_ready = 1'b0; aw_cnt++; end
         end else begin aw_ready = 1'b0; aw_cnt = 0; end
         if (w_valid) begin
            if (w_cnt >= w_wait) w_ready = 1'b1;
            else begin w_ready = 1'b0; w_cnt++; end
         end else begin w_ready = 1'b0; w_cnt = 0; end
         if (b_ready) begin
            if (b_cnt >= b_wait) begin b_valid = 1'b1; b_resp = s_bresp; end
            else begin b_valid = 1'b0; b_cnt++; end
         end else begin b_valid = 1'b0; b_cnt = 0; b_resp = '0; end
      end
   end

   // One zero-wait transaction from a single requester; called on a falling edge in IDLE.
   task automatic do_txn(input vec_t v);
      logic [1:0] onehot;
      int         lat;
      onehot  = 2'(1 << v.req);
      s_rdata = v.s_rdata; s_rresp = v.s_resp; s_bresp = v.s_resp;
      ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      req_valid = '0; req_we = '0;
      req_we[v.req]              = v.we;
      req_addr[v.req*32 +: 32]   = v.addr;
      req_wdata[v.req*32 +: 32]  = v.wdata;
      req_wstrb[v.req*4 +: 4]    = v.wstrb;
      req_valid[v.req]           = 1'b1;
      #1;
      chk("txn_req_ready", req_ready, onehot);
      @(negedge clk);
      req_valid = '0;
      if (v.we) begin
         chk("txn_aw_w_valid", {aw_valid, w_valid}, 2'b11);
         chk("txn_awdata", aw_data, v.addr);
         chk("txn_wdata", w_data, v.wdata);
         chk("txn_wstrb", w_strb, v.wstrb);
      end else begin
         chk("txn_arvalid", ar_valid, 1'b1);
         chk("txn_ardata", ar_data, v.addr);
      end
      lat = 1;
      while (rsp_valid == 2'b00 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("txn_latency", lat, 3);
      chk("txn_rsp_valid", rsp_valid, onehot);
      chk("txn_rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("txn_rsp_err", rsp_err, v.exp_err);
      @(negedge clk);
      chk("txn_rsp_pulse", rsp_valid, 2'b00);
      chk("txn_rdata_hold", rsp_rdata, v.exp_rdata);
      chk("txn_idle", dbg_state, 3'd0);
   endtask

   logic [1:0] exp_g[4];
   int         ng, nr, cyc, last_g, seen;
   vec_t       fresh;

   initial begin
      //            req we  addr          wdata         strb     s_rdata       resp   exp_rdata     err
      vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,        4'h0,    32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1, 1'b0, 32'h2000_0004, 32'h0,        4'h0,    32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 1'b0};
      vecs[2] = '{0, 1'b0, 32'h0000_0044, 32'h0,        4'h0,    32'h0BAD_F00D, 2'b10, 32'h0BAD_F00D, 1'b1};
      vecs[3] = '{1, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 4'b1111, 32'h0,        2'b00, 32'h0,         1'b0};
      vecs[4] = '{0, 1'b1, 32'h0000_0404, 32'h1122_3344, 4'b0100, 32'h0,        2'b11, 32'h0,         1'b1};
      vecs[5] = '{1, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0,    32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFF, 1'b1};
      vecs[6] = '{0, 1'b0, 32'h0000_0808, 32'h0,        4'h0,    32'h0000_005A, 2'b01, 32'h0000_005A, 1'b0};
`ifdef FIXED_PRIO_EN
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

      // reset, with requests pending to show req_ready stays low
      rst = 1'b1; req_valid = 2'b11; req_we = '0;
      req_addr = '0; req_wdata = '0; req_wstrb = '0;
      repeat (3) @(negedge clk);
      chk("rst_state", dbg_state, 3'd0);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_axi_handshakes", {ar_valid, r_ready, aw_valid, w_valid, b_ready}, 5'b0);
      chk("rst_rsp_data", {rsp_err, rsp_rdata}, 33'h0);
      chk("rst_addr_regs", {ar_data, aw_data}, 64'h0);
      chk("rst_w_regs", {w_data, w_strb}, 36'h0);
      chk("rst_prot", {ar_prot, aw_prot}, 6'h0);
      req_valid = 2'b00; rst = 1'b0;
      @(negedge clk);

      // table of single transactions
      for (int i = 0; i < 7; i++) do_txn(vecs[i]);

      // write on req1 with AWready two cycles after Wready
      aw_wait = 2; w_wait = 0; b_wait = 0; s_bresp = 2'b00;
      req_we = 2'b10; req_addr[63:32] = 32'h0000_0200;
      req_wdata[63:32] = 32'h1234_5678; req_wstrb[7:4] = 4'b0011; req_valid = 2'b10;
      #1;
      chk("t2_req_ready", req_ready, 2'b10);
      @(negedge clk); req_valid = '0;
      chk("t2_c1_aw_w_b", {aw_valid, w_valid, b_ready}, 3'b110);
      chk("t2_wdata_wstrb", {w_data, w_strb}, {32'h1234_5678, 4'b0011});
      @(negedge clk);
      chk("t2_c2_aw_w_b", {aw_valid, w_valid, b_ready}, 3'b100);
      @(negedge clk);
      chk("t2_c3_aw_w_b", {aw_valid, w_valid, b_ready}, 3'b100);
      chk("t2_awdata", aw_data, 32'h0000_0200);
      @(negedge clk);
      chk("t2_c4_aw_w_b", {aw_valid, w_valid, b_ready}, 3'b001);
      @(negedge clk);
      chk("t2_rsp_valid", rsp_valid, 2'b10);
      chk("t2_rsp", {rsp_err, rsp_rdata}, 33'h0);
      @(negedge clk);

      // write on req0 with AWready first and Wready one cycle later, SLVERR response
      aw_wait = 0; w_wait = 1; s_bresp = 2'b10;
      req_we = 2'b01; req_addr[31:0] = 32'h0000_0600;
      req_wdata[31:0] = 32'hFEED_FACE; req_wstrb[3:0] = 4'b1000; req_valid = 2'b01;
      #1;
      chk("wr2_req_ready", req_ready, 2'b01);
      @(negedge clk); req_valid = '0;
      chk("wr2_c1_aw_w_b", {aw_valid, w_valid, b_ready}, 3'b110);
      @(negedge clk);
      chk("wr2_c2_aw_w_b", {aw_valid, w_valid, b_ready}, 3'b010);
      @(negedge clk);
      chk("wr2_c3_aw_w_b", {aw_valid, w_valid, b_ready}, 3'b001);
      @(negedge clk);
      chk("wr2_rsp_valid", rsp_valid, 2'b01);
      chk("wr2_rsp_err", rsp_err, 1'b1);
      @(negedge clk);
      w_wait = 0;

      // reset again so arbitration starts from pointer 0, then both requesters read continuously
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      s_rdata = 32'h0000_0033; s_rresp = 2'b00;
      req_we = 2'b00; req_addr = {32'h0000_2000, 32'h0000_1000}; req_valid = 2'b11;
      ng = 0; nr = 0; cyc = 0; last_g = 0;
      #1;
      while ((ng < 4 || nr < 4) && cyc < 40) begin
         if (req_ready != 2'b00 && ng < 4) begin
            chk("t3_grant", req_ready, exp_g[ng]);
            if (ng > 0) chk("t3_grant_gap", cyc - last_g, 4);
            last_g = cyc;
            ng++;
         end
         if (rsp_valid != 2'b00 && nr < 4) begin
            chk("t3_rsp_valid", rsp_valid, exp_g[nr]);
            nr++;
         end
         @(negedge clk); #1;
         cyc++;
      end
      req_valid = 2'b00;
      chk("t3_grant_count", ng, 4);
      chk("t3_rsp_count", nr, 4);
      @(negedge clk);

      // AR back-pressure: ARready low for 5 cycles, req1 arrives mid-transaction
      ar_wait = 5; s_rdata = 32'h0000_5555;
      req_addr = {32'h0000_6660, 32'h0000_5550}; req_valid = 2'b01;
      #1;
      chk("t5_req_ready", req_ready, 2'b01);
      @(negedge clk);
      req_valid = 2'b10;
      for (int c = 1; c <= 6; c++) begin
         chk("t5_arvalid", ar_valid, 1'b1);
         chk("t5_ardata", ar_data, 32'h0000_5550);
         chk("t5_no_grant", req_ready, 2'b00);
         @(negedge clk);
      end
      chk("t5_no_grant_rd_d", req_ready, 2'b00);
      @(negedge clk);
      ar_wait = 0;
      chk("t5_rsp_valid", rsp_valid, 2'b01);
      chk("t5_no_grant_resp", req_ready, 2'b00);
      @(negedge clk);
      chk("t5_next_grant", req_ready, 2'b10);
      @(negedge clk);
      req_valid = 2'b00;
      chk("t5_ardata_req1", ar_data, 32'h0000_6660);
      cyc = 0;
      while (rsp_valid == 2'b00 && cyc < 20) begin @(negedge clk); cyc++; end
      chk("t5_drain_rsp", rsp_valid, 2'b10);
      @(negedge clk);

      // reset while waiting for read data
      r_wait = 10;
      req_addr[31:0] = 32'h0000_0700; req_valid = 2'b01;
      #1;
      chk("t6_req_ready", req_ready, 2'b01);
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk);
      chk("t6_in_rd_d", {dbg_state, r_ready}, {3'd2, 1'b1});
      rst = 1'b1;
      @(negedge clk);
      chk("t6_state", dbg_state, 3'd0);
      chk("t6_handshakes", {ar_valid, r_ready, aw_valid, w_valid, b_ready}, 5'b0);
      chk("t6_rsp_cleared", {rsp_err, rsp_rdata}, 33'h0);
      rst = 1'b0; r_wait = 0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (rsp_valid != 2'b00) seen++;
         @(negedge clk);
      end
      chk("t6_no_rsp", seen, 0);
      fresh = '{1, 1'b0, 32'h0000_0900, 32'h0, 4'h0, 32'h7777_0001, 2'b00, 32'h7777_0001, 1'b0};
      do_txn(fresh);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
